simon2share_seq: RTL
====================

# simon2share_seq

Sequencer for the two-share bit-serial SIMON core. It accepts one encryption job as parallel key and plaintext shares over a valid/ready handshake, then drives the core's `data_rdy` phase code and serial `data_ina`/`data_inb` lanes. It waits for the core's `Done`, captures `cipher_out`, and returns it over a second valid/ready handshake. It sits between the bus-side register block and the `simon2share` core, and is the only driver of the core's inputs.

## Interface
Parameters:
- `KEY_BITS`, 128: key bits per share, shifted MSB first.
- `BLK_BITS`, 128: plaintext bits per share, shifted MSB first.
- `CT_BITS`, 128: width of the core's `cipher_out`.
- `RUN_MAX`, 255: timeout limit in RUN cycles; used only with `SIMON_SEQ_TIMEOUT_EN`.

Ports (one clock `clk`; reset is asynchronous and active-low, `rst_n`):
- `clk`  in  1  rising-edge clock, shared with the core.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  job offered.
- `req_ready`  out  1  high only in IDLE.
- `key_a`, `key_b`  in  KEY_BITS  key shares; sampled at accept.
- `pt_a`, `pt_b`  in  BLK_BITS  plaintext shares; sampled at accept.
- `core_data_rdy`  out  2  phase code to core.
- `core_ina`, `core_inb`  out  1  serial share lanes to core.
- `core_done`  in  1  core `Done`.
- `core_cipher`  in  CT_BITS  core `cipher_out`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  CT_BITS  captured ciphertext.
- `busy`  out  1  high when the state is not IDLE.
- `err`  out  1  timeout flag; tied 0 without the macro.

## Operation
States and phase codes:
- IDLE: `data_rdy`=0.
- LOAD_KEY: `data_rdy`=1.
- LOAD_PT: `data_rdy`=2.
- RUN: `data_rdy`=3.
- RESP: `data_rdy`=0.

Transitions:
- Accept occurs when `req_valid & req_ready`. On accept, all four share words are latched into shift registers and the state goes to LOAD_KEY.
- LOAD_KEY: for KEY_BITS cycles, `core_ina`/`core_inb` carry `key_a`/`key_b` MSB first. After the last bit, go to LOAD_PT.
- LOAD_PT: same for `pt_a`/`pt_b` over BLK_BITS cycles. After the last bit, go to RUN.
- RUN: lanes are driven 0. On `core_done`=1, `core_cipher` is captured into `res_data` the same edge, and the state goes to RESP.
- RESP: `res_valid`=1, with `res_data` stable, until `res_ready`. On the handshake, go to IDLE.
- IDLE after RESP always lasts at least one cycle. This guarantees `data_rdy`=0 clears the core round counter before the next job.
- `core_done` outside RUN is ignored.
- `req_valid` and the share inputs are don't-care after accept.

Bit counter:
- Width is `$clog2(max(KEY_BITS,BLK_BITS))+1`.
- Loaded with KEY_BITS-1 at accept and BLK_BITS-1 on entry to LOAD_PT.
- Decremented each load cycle; the phase ends when it reaches 0. It never wraps.

Reset (any time, including mid-load or mid-RUN):
- All outputs go to 0 immediately: `core_data_rdy`=0, lanes 0, `res_valid`=0, `busy`=0, `err`=0, `res_data`=0.
- State goes to IDLE. `req_ready` rises on the first clock after `rst_n` deasserts.

## Timing
- Accept at edge T. Cycles T+1 … T+KEY_BITS carry `data_rdy`=1 with key bit KEY_BITS-1 first.
- Next BLK_BITS cycles carry `data_rdy`=2.
- RUN begins at T+KEY_BITS+BLK_BITS+1.
- `res_valid` rises the cycle after `core_done` is sampled.
- All core-facing outputs are registered; there is no combinational path from `core_done` or `res_ready` to any output.
- Throughput: one job per KEY_BITS+BLK_BITS+run+3 cycles at minimum (accept, RESP, IDLE gap).

## Configuration
- `SIMON_SEQ_TIMEOUT_EN` defined:
  - A RUN-cycle counter aborts the job if `core_done` is not seen within RUN_MAX cycles.
  - On abort, the sequencer drives `data_rdy`=0, sets `err`=1, and enters RESP with `res_data`=0.
  - `err` clears at the RESP handshake.
- Macro undefined: the counter is absent, RUN waits indefinitely, and `err` is constant 0.

## Structure
- Package `simon_seq_pkg` holds:
  - the state enum;
  - phase-code localparams `PH_IDLE`=0, `PH_KEY`=1, `PH_PT`=2, `PH_RUN`=3.
- Sub-module `simon_seq_piso`: a dual-lane parallel-load, MSB-first shift register with a width parameter. It is instantiated once for key and once for plaintext; the FSM selects which one drives the lanes.

## Test plan
- Reset release, then one job with `key_a`=0x0F0E0D0C0B0A0908_0706050403020100, `key_b`=0, `pt_a`=0x6373656420737265_6c6c657661727420, `pt_b`=0. Required:
  - `data_rdy` shows 1 for 128 cycles, then 2 for 128 cycles, then 3.
  - Lanes match the words MSB first.
  - `res_data` equals the core's reference ciphertext.
- Same job with random masks (`key_b`=R1, `key_a`=K^R1, `pt_b`=R2, `pt_a`=P^R2). Required: XOR-recombined `res_data` matches the unmasked result.
- `res_ready` held low for 20 cycles after `res_valid`. Required: `res_data` stable, `req_ready`=0, `data_rdy`=0 throughout.
- Back-to-back jobs with `req_valid` held high. Required: at least one IDLE cycle with `data_rdy`=0 between them, and the second result is correct.
- `rst_n` pulsed low at bit 40 of LOAD_PT. Required: all outputs 0 asynchronously, and a fresh job then completes correctly.
- With `SIMON_SEQ_TIMEOUT_EN`, a core stub that never asserts Done and `RUN_MAX`=10. Required: `err`=1 and `res_valid`=1 eleven cycles after RUN entry, with `res_data`=0.

Source files
------------

// File: rtl/simon_seq_pkg.sv
// Shared types and constants for the two-share SIMON sequencer.
// Holds the FSM state encoding and the data_rdy phase codes seen by the core.
package simon_seq_pkg;

    // Sequencer states; IDLE and RESP both present phase code 0 to the core.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_PT  = 3'd2,
        S_RUN      = 3'd3,
        S_RESP     = 3'd4
    } seq_state_t;

    // Phase codes driven on the core's data_rdy input.
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_KEY  = 2'd1;
    localparam logic [1:0] PH_PT   = 2'd2;
    localparam logic [1:0] PH_RUN  = 2'd3;

    // Larger of two widths; sizes the shared load bit counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/simon_seq_piso.sv
// Dual-lane parallel-load shift register, MSB first.
// Lane 0 carries share A, lane 1 carries share B; both shift in lockstep.
module simon_seq_piso #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din_a,
    input  logic [W-1:0] din_b,
    output logic         msb_a,
    output logic         msb_b
);

    logic [W-1:0] din [2];
    logic [1:0]   msb;

    assign din[0] = din_a;
    assign din[1] = din_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [W-1:0] sr_reg;

            // Load the whole share word, then move it towards the MSB one bit per shift.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_reg <= '0;
                end else if (load) begin
                    sr_reg <= din[gi];
                end else if (shift) begin
                    sr_reg <= {sr_reg[W-2:0], 1'b0};
                end
            end

            assign msb[gi] = sr_reg[W-1];
        end
    endgenerate

    assign msb_a = msb[0];
    assign msb_b = msb[1];

endmodule

// File: rtl/simon2share_seq.sv
// Sequencer for the two-share bit-serial SIMON core.
// Accepts a masked key/plaintext job, streams it into the core with the
// data_rdy phase code, waits for Done and hands the ciphertext back.
// Optional build macro: SIMON_SEQ_TIMEOUT_EN adds a RUN-phase timeout that
// aborts the job and raises err.
module simon2share_seq
    import simon_seq_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int BLK_BITS = 128,
    parameter int CT_BITS  = 128,
    parameter int RUN_MAX  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_BITS-1:0] key_a,
    input  logic [KEY_BITS-1:0] key_b,
    input  logic [BLK_BITS-1:0] pt_a,
    input  logic [BLK_BITS-1:0] pt_b,
    output logic [1:0]          core_data_rdy,
    output logic                core_ina,
    output logic                core_inb,
    input  logic                core_done,
    input  logic [CT_BITS-1:0]  core_cipher,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CT_BITS-1:0]  res_data,
    output logic                busy,
    output logic                err
);

    localparam int CNT_W = $clog2(max_int(KEY_BITS, BLK_BITS)) + 1;

    seq_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                req_ready_reg;
    logic [CT_BITS-1:0]  res_data_reg;
    logic                load, key_shift, pt_shift;
    logic                capture, abort, resp_done;
    logic                key_msb_a, key_msb_b, pt_msb_a, pt_msb_b;

    simon_seq_piso #(.W(KEY_BITS)) u_key_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (key_shift),
        .din_a (key_a),
        .din_b (key_b),
        .msb_a (key_msb_a),
        .msb_b (key_msb_b)
    );

    simon_seq_piso #(.W(BLK_BITS)) u_pt_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (pt_shift),
        .din_a (pt_a),
        .din_b (pt_b),
        .msb_a (pt_msb_a),
        .msb_b (pt_msb_b)
    );

`ifdef SIMON_SEQ_TIMEOUT_EN
    localparam int RUN_W = $clog2(RUN_MAX + 1);

    logic [RUN_W-1:0] run_cnt_reg;
    logic             err_reg;
    logic             run_expired;

    assign run_expired = (run_cnt_reg == RUN_W'(RUN_MAX));

    // Count cycles spent in RUN; restarts from zero whenever RUN is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_reg <= '0;
        end else if (state_reg == S_RUN) begin
            run_cnt_reg <= run_cnt_reg + RUN_W'(1);
        end else begin
            run_cnt_reg <= '0;
        end
    end

    // Timeout flag: set on abort, held through RESP, cleared by the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (abort) begin
            err_reg <= 1'b1;
        end else if (resp_done) begin
            err_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`else
    // Without the timeout the flag is a constant zero.
    localparam logic ERR_TIE = 1'b0 && (RUN_MAX > 0);
    assign err = ERR_TIE;
`endif

    // State, bit counter and accept-ready register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_ready_reg <= (state_next == S_IDLE);
        end
    end

    // Ciphertext capture on Done, zeroed on a timeout abort, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_reg <= '0;
        end else if (capture) begin
            res_data_reg <= core_cipher;
        end else if (abort) begin
            res_data_reg <= '0;
        end
    end

    // Next-state logic; req_ready_reg gates accept so no job is taken before
    // the first clock after reset release.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        key_shift  = 1'b0;
        pt_shift   = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        resp_done  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid && req_ready_reg) begin
                    load       = 1'b1;
                    cnt_next   = CNT_W'(KEY_BITS - 1);
                    state_next = S_LOAD_KEY;
                end
            end
            S_LOAD_KEY: begin
                key_shift = 1'b1;
                if (cnt_reg == '0) begin
                    cnt_next   = CNT_W'(BLK_BITS - 1);
                    state_next = S_LOAD_PT;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_LOAD_PT: begin
                pt_shift = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = S_RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (core_done) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
`ifdef SIMON_SEQ_TIMEOUT_EN
                else if (run_expired) begin
                    abort      = 1'b1;
                    state_next = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (res_ready) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Core-facing decode from registered state and shift-register MSBs only.
    always_comb begin
        core_data_rdy = PH_IDLE;
        core_ina      = 1'b0;
        core_inb      = 1'b0;
        case (state_reg)
            S_LOAD_KEY: begin
                core_data_rdy = PH_KEY;
                core_ina      = key_msb_a;
                core_inb      = key_msb_b;
            end
            S_LOAD_PT: begin
                core_data_rdy = PH_PT;
                core_ina      = pt_msb_a;
                core_inb      = pt_msb_b;
            end
            S_RUN:   core_data_rdy = PH_RUN;
            default: core_data_rdy = PH_IDLE;
        endcase
    end

    assign req_ready = req_ready_reg;
    assign res_valid = (state_reg == S_RESP);
    assign busy      = (state_reg != S_IDLE);
    assign res_data  = res_data_reg;

endmodule
